// File: rtl/pattern_scan_pkg.sv
// Shared constants for the pattern scan controller: FSM encoding and default widths.
package pattern_scan_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   localparam int DATA_W_DEF = 8;
   localparam int PAT_W_DEF  = 3;
   localparam int CNT_W_DEF  = 16;

   // Bits needed for a fill counter that saturates at n.
   function automatic int fill_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bit_pattern_matcher.sv
// Serial PAT_W-bit pattern matcher; match is combinational on the bit being fed.
module bit_pattern_matcher
   import pattern_scan_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             bit_vld,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             match
);

   localparam int                FILL_W    = fill_width(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  hist_nxt;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_nxt;

   always_comb begin
      hist_nxt = {hist[PAT_W-2:0], bit_in};
      fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
      match    = bit_vld && (fill_nxt == FILL_FULL) && (hist_nxt == pattern);
   end

   // Non-overlap mode restarts the fill so the next match needs PAT_W fresh bits.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist <= '0;
         fill <= '0;
      end else if (bit_vld) begin
         hist <= hist_nxt;
         fill <= (match && !overlap) ? '0 : fill_nxt;
      end
   end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Job controller: accepts words on a valid/ready stream, serialises them MSB-first
// through the pattern matcher and counts matches per job.
//
//   state | meaning
//   IDLE  | waiting for start; match_count holds last job's result
//   LOAD  | s_ready high, waiting for the next word
//   SHIFT | one bit per clock into the matcher
//   FIN   | done pulse, back to IDLE
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PAT_W  = PAT_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  job_len,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic              cfg_overlap,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              match_pulse,
   output logic [CNT_W-1:0]  match_count,
   output logic              busy,
   output logic              done
);

   localparam int               IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]        state;
   logic [CNT_W-1:0]  words_left;
   logic [DATA_W-1:0] word_q;
   logic [IDX_W-1:0]  bit_idx;
   logic [PAT_W-1:0]  pattern_q;
   logic              overlap_q;
   logic              start_job;
   logic              bit_vld;
   logic              match;

   assign s_ready   = (state == ST_LOAD);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FIN);
   assign start_job = (state == ST_IDLE) && start;
   assign bit_vld   = (state == ST_SHIFT);

   bit_pattern_matcher #(
      .PAT_W (PAT_W)
   ) u_matcher (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_job),
      .bit_vld (bit_vld),
      .bit_in  (word_q[DATA_W-1]),
      .pattern (pattern_q),
      .overlap (overlap_q),
      .match   (match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         words_left  <= '0;
         word_q      <= '0;
         bit_idx     <= '0;
         pattern_q   <= '0;
         overlap_q   <= 1'b0;
         match_pulse <= 1'b0;
         match_count <= '0;
      end else begin
         match_pulse <= match;
         if (match && (match_count != CNT_MAX))
            match_count <= match_count + CNT_W'(1);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  pattern_q   <= cfg_pattern;
                  overlap_q   <= cfg_overlap;
                  words_left  <= job_len;
                  match_count <= '0;
                  state       <= (job_len == '0) ? ST_FIN : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (s_valid) begin
                  word_q     <= s_data;
                  bit_idx    <= '0;
                  words_left <= words_left - CNT_W'(1);
                  state      <= ST_SHIFT;
               end
            end
            // word_q shifts left so its MSB is always the bit being fed.
            ST_SHIFT: begin
               word_q  <= word_q << 1;
               bit_idx <= bit_idx + IDX_W'(1);
               if (bit_idx == IDX_LAST)
                  state <= (words_left == '0) ? ST_FIN : ST_LOAD;
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
